// File: rtl/ship_placement_ctrl.sv
// ship_placement_ctrl
//
// Sequences the ship-placement phase of the game. Debounced button pulses
// move a cursor, rotate the ghost ship and request placement. A requested
// placement is walked cell by cell against the board edges and an internal
// occupancy map. An accepted ship is then written into that map, again one
// cell per cycle. The display side can look up any tile through a registered
// occupancy query port.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start               clear board and begin placement (IDLE/DONE only)
//   btn_up/down/left/right, btn_rotate, btn_place
//                       single-cycle command pulses, acted on in MOVE only
//   query_x, query_y    tile to look up
//   query_hit           registered occupancy of the queried tile
//   cursor              {cursor_x, cursor_y} of the ghost ship origin
//   orientation         0=NORTH(-y) 1=EAST(+x) 2=SOUTH(+y) 3=WEST(-x)
//   length              length code of the ship being placed
//   ship_idx            index of the ship being placed
//   busy                high while a placement is checked or committed
//   place_ok, place_err one-cycle result pulses of a placement request
//   all_placed          high once the whole fleet is on the board
module ship_placement_ctrl #(
   parameter int GRID_SIZE = 10,
   parameter int NUM_SHIPS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       btn_place,
   input  logic [3:0] query_x,
   input  logic [3:0] query_y,
   output logic       query_hit,
   output logic [7:0] cursor,
   output logic [1:0] orientation,
   output logic [2:0] length,
   output logic [2:0] ship_idx,
   output logic       busy,
   output logic       place_ok,
   output logic       place_err,
   output logic       all_placed
);

   typedef enum logic [2:0] {IDLE, MOVE, CHECK, COMMIT, DONE} state_t;

   localparam logic [3:0] MAX_COORD  = 4'(GRID_SIZE - 1);
   localparam logic [4:0] GRID_LIMIT = 5'(GRID_SIZE);
   localparam logic [2:0] LAST_SHIP  = 3'(NUM_SHIPS - 1);

   state_t state, state_n;
   logic [3:0] cur_x, cur_x_n;
   logic [3:0] cur_y, cur_y_n;
   logic [1:0] orient, orient_n;
   logic [2:0] ship, ship_n;
   logic [2:0] k, k_n;
   logic       place_ok_n, place_err_n;
   logic       clear_occ, set_occ;
   logic [4:0] cell_x, cell_y;
   logic       cell_in_bounds, cell_occupied;
   logic [GRID_SIZE-1:0] occ [GRID_SIZE];

   // Fixed fleet: ship 0..4 has length code 4,3,2,2,1. Anything past the
   // last ship (the DONE state) keeps showing the smallest ship's code.
   always_comb begin
      case (ship)
         3'd0:    length = 3'd4;
         3'd1:    length = 3'd3;
         3'd2:    length = 3'd2;
         3'd3:    length = 3'd2;
         default: length = 3'd1;
      endcase
   end

   // Cell k of the ship under test, in 5-bit two's complement. A step off
   // the low edge sets bit 4, and so does running past coordinate 15. In
   // both cases the unsigned value is >= 16, so one unsigned compare against
   // GRID_SIZE catches both edges.
   always_comb begin
      cell_x = {1'b0, cur_x};
      cell_y = {1'b0, cur_y};
      case (orient)
         2'd0:    cell_y = {1'b0, cur_y} - {2'b00, k};
         2'd1:    cell_x = {1'b0, cur_x} + {2'b00, k};
         2'd2:    cell_y = {1'b0, cur_y} + {2'b00, k};
         default: cell_x = {1'b0, cur_x} - {2'b00, k};
      endcase
   end

   assign cell_in_bounds = (cell_x < GRID_LIMIT) && (cell_y < GRID_LIMIT);

   // The map is only read for on-board cells, so the index never leaves the
   // array even on boards smaller than 16 tiles.
   always_comb begin
      cell_occupied = 1'b0;
      if (cell_in_bounds) begin
         cell_occupied = occ[cell_y[3:0]][cell_x[3:0]];
      end
   end

   // Next-state and datapath decisions. Only one button is honoured per
   // cycle in MOVE, with place > rotate > up > down > left > right. CHECK
   // walks cells 0..length and stops at the first bad one. COMMIT walks
   // the same cells again and marks them occupied.
   always_comb begin
      state_n     = state;
      cur_x_n     = cur_x;
      cur_y_n     = cur_y;
      orient_n    = orient;
      ship_n      = ship;
      k_n         = k;
      place_ok_n  = 1'b0;
      place_err_n = 1'b0;
      clear_occ   = 1'b0;
      set_occ     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n   = MOVE;
               cur_x_n   = '0;
               cur_y_n   = '0;
               orient_n  = '0;
               ship_n    = '0;
               k_n       = '0;
               clear_occ = 1'b1;
            end
         end
         MOVE: begin
            if (btn_place) begin
               state_n = CHECK;
               k_n     = '0;
            end else if (btn_rotate) begin
               orient_n = orient + 2'd1;
            end else if (btn_up) begin
               if (cur_y != 4'd0) cur_y_n = cur_y - 4'd1;
            end else if (btn_down) begin
               if (cur_y != MAX_COORD) cur_y_n = cur_y + 4'd1;
            end else if (btn_left) begin
               if (cur_x != 4'd0) cur_x_n = cur_x - 4'd1;
            end else if (btn_right) begin
               if (cur_x != MAX_COORD) cur_x_n = cur_x + 4'd1;
            end
         end
         CHECK: begin
            if (!cell_in_bounds || cell_occupied) begin
               place_err_n = 1'b1;
               state_n     = MOVE;
               k_n         = '0;
            end else if (k == length) begin
               state_n = COMMIT;
               k_n     = '0;
            end else begin
               k_n = k + 3'd1;
            end
         end
         COMMIT: begin
            set_occ = 1'b1;
            if (k == length) begin
               place_ok_n = 1'b1;
               ship_n     = ship + 3'd1;
               k_n        = '0;
               state_n    = (ship == LAST_SHIP) ? DONE : MOVE;
            end else begin
               k_n = k + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Control and cursor registers. The result pulses are registered, so
   // they appear the cycle after the deciding CHECK or final COMMIT step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cur_x     <= '0;
         cur_y     <= '0;
         orient    <= '0;
         ship      <= '0;
         k         <= '0;
         place_ok  <= 1'b0;
         place_err <= 1'b0;
      end else begin
         state     <= state_n;
         cur_x     <= cur_x_n;
         cur_y     <= cur_y_n;
         orient    <= orient_n;
         ship      <= ship_n;
         k         <= k_n;
         place_ok  <= place_ok_n;
         place_err <= place_err_n;
      end
   end

   // Occupancy map. Reset and start both wipe it, which also discards a
   // ship whose commit was interrupted by reset. COMMIT only visits cells
   // that CHECK has already proven to be on the board.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < GRID_SIZE; i++) occ[i] <= '0;
      end else if (clear_occ) begin
         for (int i = 0; i < GRID_SIZE; i++) occ[i] <= '0;
      end else if (set_occ) begin
         occ[cell_y[3:0]][cell_x[3:0]] <= 1'b1;
      end
   end

   // Display lookup: one cycle of latency, off-board tiles read as empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         query_hit <= 1'b0;
      end else if (({1'b0, query_x} < GRID_LIMIT) && ({1'b0, query_y} < GRID_LIMIT)) begin
         query_hit <= occ[query_y][query_x];
      end else begin
         query_hit <= 1'b0;
      end
   end

   assign cursor      = {cur_x, cur_y};
   assign orientation = orient;
   assign ship_idx    = ship;
   assign busy        = (state == CHECK) || (state == COMMIT);
   assign all_placed  = (state == DONE);

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// tb_ship_placement_ctrl
//
// Drives ship_placement_ctrl with a table of cursor/rotate vectors, a set of
// hand-written placement scenarios, and randomized games. Every result is
// compared with a behavioural model of the board: cursor, heading, fleet
// index and an occupancy array.
module tb_ship_placement_ctrl;

   localparam int G = 10;
   localparam int PH_IDLE = 0;
   localparam int PH_MOVE = 1;
   localparam int PH_DONE = 2;

   logic       clk, rst, start;
   logic       btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place;
   logic [3:0] query_x, query_y;
   logic       query_hit;
   logic [7:0] cursor;
   logic [1:0] orientation;
   logic [2:0] length, ship_idx;
   logic       busy, place_ok, place_err, all_placed;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the game.
   int m_x, m_y, m_o, m_ship, m_phase;
   bit m_occ [16][16];
   int lens [5] = '{4, 3, 2, 2, 1};
   int dxs  [4] = '{0, 1, 0, -1};
   int dys  [4] = '{-1, 0, 1, 0};

   typedef struct {
      logic [4:0] btns;
      logic [7:0] exp_cursor;
      logic [1:0] exp_orient;
   } vec_t;
   vec_t vecs [13];

   ship_placement_ctrl #(.GRID_SIZE(G), .NUM_SHIPS(5)) dut (
      .clk(clk), .rst(rst), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_rotate(btn_rotate), .btn_place(btn_place),
      .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
      .cursor(cursor), .orientation(orientation), .length(length),
      .ship_idx(ship_idx), .busy(busy), .place_ok(place_ok),
      .place_err(place_err), .all_placed(all_placed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hang guard so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int clampCoord(input int v);
      if (v < 0) return 0;
      if (v > G - 1) return G - 1;
      return v;
   endfunction

   function automatic int expLen();
      return (m_ship < 5) ? lens[m_ship] : 1;
   endfunction

   // Index of the first cell that is off-board or taken, or -1 if all fit.
   function automatic int firstFailAt(input int x0, input int y0, input int o);
      int x, y;
      for (int c = 0; c <= expLen(); c++) begin
         x = x0 + c * dxs[o];
         y = y0 + c * dys[o];
         if (x < 0 || x >= G || y < 0 || y >= G) return c;
         if (m_occ[y][x]) return c;
      end
      return -1;
   endfunction

   task automatic modelClear();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) m_occ[y][x] = 1'b0;
      m_x = 0; m_y = 0; m_o = 0; m_ship = 0;
   endtask

   task automatic modelStep(input logic [4:0] b, input logic st);
      if (st && m_phase != PH_MOVE) begin
         modelClear();
         m_phase = PH_MOVE;
      end else if (m_phase == PH_MOVE) begin
         if (b[4])      m_o = (m_o + 1) % 4;
         else if (b[3]) m_y = clampCoord(m_y - 1);
         else if (b[2]) m_y = clampCoord(m_y + 1);
         else if (b[1]) m_x = clampCoord(m_x - 1);
         else if (b[0]) m_x = clampCoord(m_x + 1);
      end
   endtask

   // One cycle of {rotate, up, down, left, right} plus start.
   task automatic applyStimulus(input logic [4:0] b, input logic st);
      @(negedge clk);
      {btn_rotate, btn_up, btn_down, btn_left, btn_right} = b;
      start = st;
      @(negedge clk);
      {btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
      start = 1'b0;
      modelStep(b, st);
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, " cursor"}, int'(cursor), m_x * 16 + m_y);
      checkOutput({tag, " orientation"}, int'(orientation), m_o);
      checkOutput({tag, " ship_idx"}, int'(ship_idx), m_ship);
      checkOutput({tag, " length"}, int'(length), expLen());
      checkOutput({tag, " all_placed"}, int'(all_placed), int'(m_phase == PH_DONE));
      checkOutput({tag, " busy"}, int'(busy), 0);
   endtask

   task automatic cmd(input logic [4:0] b, input logic st);
      applyStimulus(b, st);
      checkModel("cmd");
   endtask

   task automatic goTo(input int tx, input int ty, input int to);
      for (int i = 0; i < 4 && m_o != to; i++) cmd(5'b10000, 1'b0);
      for (int i = 0; i < 16 && m_x < tx; i++) cmd(5'b00001, 1'b0);
      for (int i = 0; i < 16 && m_x > tx; i++) cmd(5'b00010, 1'b0);
      for (int i = 0; i < 16 && m_y < ty; i++) cmd(5'b00100, 1'b0);
      for (int i = 0; i < 16 && m_y > ty; i++) cmd(5'b01000, 1'b0);
   endtask

   // Place request with optional same-cycle lower-priority buttons and
   // random button/start noise for as long as the DUT reports busy.
   task automatic doPlace(input logic [4:0] extra);
      int f, len, lat, busy_cnt, exp_lat, exp_busy;
      len = expLen();
      f = firstFailAt(m_x, m_y, m_o);
      if (f < 0) begin
         exp_lat = 2 * (len + 1) + 1;
         exp_busy = 2 * (len + 1);
      end else begin
         exp_lat = f + 2;
         exp_busy = f + 1;
      end
      @(negedge clk);
      btn_place = 1'b1;
      {btn_rotate, btn_up, btn_down, btn_left, btn_right} = extra;
      @(negedge clk);
      {btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
      lat = 1;
      busy_cnt = 0;
      while (!(place_ok || place_err) && lat < 40) begin
         if (busy) begin
            busy_cnt++;
            {btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = 6'($urandom);
            start = 1'($urandom);
         end else begin
            {btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      {btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
      start = 1'b0;
      checkOutput("place_ok result", int'(place_ok), int'(f < 0));
      checkOutput("place_err result", int'(place_err), int'(f >= 0));
      checkOutput("place latency", lat, exp_lat);
      checkOutput("busy cycles", busy_cnt, exp_busy);
      if (f < 0) begin
         for (int c = 0; c <= len; c++) m_occ[m_y + c * dys[m_o]][m_x + c * dxs[m_o]] = 1'b1;
         m_ship++;
         if (m_ship == 5) m_phase = PH_DONE;
      end
      @(negedge clk);
      checkOutput("place_ok pulse width", int'(place_ok), 0);
      checkOutput("place_err pulse width", int'(place_err), 0);
      checkModel("after place");
   endtask

   // Full 16x16 query sweep, including off-board coordinates.
   task automatic checkBoard(input string tag);
      logic [15:0] row, exp_row;
      for (int y = 0; y < 16; y++) begin
         row = '0;
         exp_row = '0;
         for (int x = 0; x < 16; x++) begin
            @(negedge clk);
            query_x = 4'(x);
            query_y = 4'(y);
            @(negedge clk);
            row[x] = query_hit;
            exp_row[x] = (x < G && y < G) ? m_occ[y][x] : 1'b0;
         end
         checkOutput($sformatf("%s row %0d", tag, y), int'(row), int'(exp_row));
      end
   endtask

   // Place the remaining ships at the first spots the model accepts.
   task automatic finishGame();
      int fx, fy, fo;
      bit found;
      for (int guard = 0; guard < 8 && m_phase == PH_MOVE; guard++) begin
         found = 1'b0;
         fx = 0; fy = 0; fo = 0;
         for (int o = 0; o < 4; o++)
            for (int y = 0; y < G; y++)
               for (int x = 0; x < G; x++)
                  if (!found && firstFailAt(x, y, o) < 0) begin
                     found = 1'b1;
                     fx = x; fy = y; fo = o;
                  end
         goTo(fx, fy, fo);
         doPlace(5'b00000);
      end
   endtask

   task automatic randomGame(input int max_cmds);
      int r;
      for (int n = 0; n < max_cmds && m_phase == PH_MOVE; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) doPlace(5'($urandom));
         else if (r == 2) cmd(5'($urandom), 1'b1);
         else if (r < 6) cmd(5'($urandom), 1'b0);
         else cmd(5'(1 << $urandom_range(0, 3)), 1'b0);
      end
      finishGame();
      checkOutput("game all_placed", int'(all_placed), 1);
      checkBoard("game board");
   endtask

   initial begin
      vecs[0]  = '{5'b00010, 8'h00, 2'd0};   // left at x=0 saturates
      vecs[1]  = '{5'b01000, 8'h00, 2'd0};   // up at y=0 saturates
      vecs[2]  = '{5'b00001, 8'h10, 2'd0};   // right
      vecs[3]  = '{5'b00100, 8'h11, 2'd0};   // down
      vecs[4]  = '{5'b10001, 8'h11, 2'd1};   // rotate beats right
      vecs[5]  = '{5'b01100, 8'h10, 2'd1};   // up beats down
      vecs[6]  = '{5'b00111, 8'h11, 2'd1};   // down beats left/right
      vecs[7]  = '{5'b00011, 8'h01, 2'd1};   // left beats right
      vecs[8]  = '{5'b10000, 8'h01, 2'd2};
      vecs[9]  = '{5'b11111, 8'h01, 2'd3};   // rotate beats everything
      vecs[10] = '{5'b10000, 8'h01, 2'd0};   // heading wraps
      vecs[11] = '{5'b00000, 8'h01, 2'd0};
      vecs[12] = '{5'b00101, 8'h02, 2'd0};   // down beats right

      rst = 1'b1; start = 1'b0;
      {btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
      query_x = '0; query_y = '0;
      m_phase = PH_IDLE;
      modelClear();
      repeat (2) @(negedge clk);
      checkOutput("reset cursor", int'(cursor), 0);
      checkOutput("reset orientation", int'(orientation), 0);
      checkOutput("reset ship_idx", int'(ship_idx), 0);
      checkOutput("reset length", int'(length), 4);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset place_ok", int'(place_ok), 0);
      checkOutput("reset place_err", int'(place_err), 0);
      checkOutput("reset all_placed", int'(all_placed), 0);
      checkOutput("reset query_hit", int'(query_hit), 0);
      rst = 1'b0;

      cmd(5'b00001, 1'b0);                   // ignored in IDLE
      cmd(5'b00000, 1'b1);                   // start

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].btns, 1'b0);
         checkOutput($sformatf("vec%0d cursor", i), int'(cursor), int'(vecs[i].exp_cursor));
         checkOutput($sformatf("vec%0d orientation", i), int'(orientation), int'(vecs[i].exp_orient));
      end

      // Ship 0 pointing NORTH from the corner: second cell is off-board.
      goTo(0, 0, 0);
      doPlace(5'b00000);
      checkOutput("north reject ship_idx", int'(ship_idx), 0);
      checkBoard("after north reject");

      // Ship 0 EAST from the corner, with a dropped same-cycle right.
      goTo(0, 0, 1);
      doPlace(5'b00001);
      checkOutput("first ship ship_idx", int'(ship_idx), 1);
      checkOutput("first ship length", int'(length), 3);
      checkOutput("first ship cursor", int'(cursor), 8'h00);
      checkBoard("after first ship");

      // Ship 1 SOUTH overlapping (2,0), then shifted down one row.
      goTo(2, 0, 2);
      doPlace(5'b00000);
      checkOutput("overlap ship_idx", int'(ship_idx), 1);
      goTo(2, 1, 2);
      doPlace(5'b00000);
      checkOutput("shifted ship_idx", int'(ship_idx), 2);
      checkBoard("after second ship");

      // Edge saturation and start being ignored during MOVE.
      goTo(0, 8, 2);
      for (int i = 0; i < 5; i++) cmd(5'b00010, 1'b0);
      cmd(5'b00100, 1'b0);
      cmd(5'b00100, 1'b0);
      checkOutput("saturated cursor", int'(cursor), 8'h09);
      cmd(5'b00000, 1'b1);
      checkOutput("start in MOVE ship_idx", int'(ship_idx), 2);

      finishGame();
      checkOutput("done all_placed", int'(all_placed), 1);
      checkOutput("done ship_idx", int'(ship_idx), 5);
      checkOutput("done length", int'(length), 1);
      checkBoard("full board");
      for (int i = 0; i < 4; i++) cmd(5'($urandom), 1'b0);
      cmd(5'b00000, 1'b1);
      checkOutput("restart all_placed", int'(all_placed), 0);
      checkBoard("cleared board");

      for (int g = 0; g < 3; g++) begin
         randomGame(250);
         cmd(5'b00000, 1'b1);
      end

      // Asynchronous reset in the middle of a COMMIT.
      goTo(3, 3, 1);
      @(negedge clk);
      btn_place = 1'b1;
      @(negedge clk);
      btn_place = 1'b0;
      repeat (6) @(negedge clk);
      query_x = 4'd3;
      query_y = 4'd3;
      @(negedge clk);
      checkOutput("mid commit busy", int'(busy), 1);
      checkOutput("mid commit query_hit", int'(query_hit), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset cursor", int'(cursor), 0);
      checkOutput("async reset orientation", int'(orientation), 0);
      checkOutput("async reset ship_idx", int'(ship_idx), 0);
      checkOutput("async reset length", int'(length), 4);
      checkOutput("async reset busy", int'(busy), 0);
      checkOutput("async reset place_ok", int'(place_ok), 0);
      checkOutput("async reset query_hit", int'(query_hit), 0);
      @(negedge clk);
      rst = 1'b0;
      m_phase = PH_IDLE;
      modelClear();
      checkModel("after async reset");
      checkBoard("after async reset");
      cmd(5'b00001, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ship_placement_ctrl.md
Name: ship_placement_ctrl

Overview:
Sequences the ship-placement phase of the game. It takes debounced button pulses and moves a cursor, rotates the ship and places it. Each placement is validated against board bounds and an internal occupancy map, and accepted ships are committed to that map. It drives cursor/orientation/length to the ghost-ship renderer and answers per-tile occupancy queries for the display.

Parameters:
GRID_SIZE, 10, board edge in tiles (legal coords 0..GRID_SIZE-1, max 16)
NUM_SHIPS, 5, ships per fleet; length table fixed: ship 0..4 -> length 4,3,2,2,1 (tiles covered = length+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: clear board, begin placement (honoured in IDLE and DONE only)
btn_up/btn_down/btn_left/btn_right  in  1 each  single-cycle move pulses
btn_rotate  in  1  single-cycle rotate pulse
btn_place  in  1  single-cycle place request
query_x, query_y  in  4 each  tile to look up
query_hit  out  1  registered occupancy of (query_x,query_y); 0 if coordinate >= GRID_SIZE
cursor  out  8  {cursor_x[3:0], cursor_y[3:0]}
orientation  out  2  0=NORTH(-y) 1=EAST(+x) 2=SOUTH(+y) 3=WEST(-x)
length  out  3  current ship length code
ship_idx  out  3  index of ship being placed
busy  out  1  high in CHECK and COMMIT
place_ok  out  1  one-cycle pulse on successful commit
place_err  out  1  one-cycle pulse on rejected placement
all_placed  out  1  high in DONE

Behaviour:
- Reset: state IDLE, cursor 8'h00, orientation 0, ship_idx 0, length 4, occupancy all 0; busy, place_ok, place_err, all_placed, query_hit all 0.
- States: IDLE, MOVE, CHECK, COMMIT, DONE.
- IDLE/DONE + start -> MOVE next cycle. Clear occupancy, ship_idx=0, cursor=0, orientation=0.
- MOVE: one command acted on per cycle, priority place > rotate > up > down > left > right; lower-priority pulses in the same cycle are dropped.
- Moves: up = y-1, down = y+1, left = x-1, right = x+1. Saturate at 0 and GRID_SIZE-1 (no wrap).
- Rotate: orientation = orientation+1 mod 4. The ghost may extend off-board; only placement is checked.
- Place: MOVE -> CHECK and clear cell counter k to 0.
- CHECK: one cell per cycle, k = 0..length. Cell = cursor + k*dir, computed in 5-bit signed arithmetic. Fail if the coordinate is <0, >=GRID_SIZE, or already occupied.
  - On first failure: place_err pulses the next cycle and the state returns to MOVE.
  - If all length+1 cells pass: COMMIT with k=0.
- COMMIT: set occupancy of cell k, one per cycle, for k=0..length. After the last cell, pulse place_ok and increment ship_idx.
  - Then go to DONE if ship_idx reaches NUM_SHIPS, else MOVE.
  - Cursor and orientation persist between ships.
- Latency from btn_place to place_ok is 2*(length+1)+1 cycles. For ship 0 that is 11 cycles.
- Buttons are ignored in IDLE, CHECK, COMMIT and DONE. start is ignored in MOVE, CHECK and COMMIT.
- length is a combinational decode of ship_idx; in DONE it holds the ship 4 code (1).
- query_hit has 1-cycle latency and is valid in every state. It reflects commits from the previous cycle onward.
- Asynchronous rst mid-CHECK/COMMIT aborts immediately to reset values; a partially committed ship is discarded because occupancy is cleared.

Test Plan:
- Reset, start, then btn_place at (0,0) EAST -> busy for 10 cycles, place_ok at cycle 11, query (0..4,0) hit=1, (5,0) hit=0, ship_idx=1, length=3.
- Five left pulses at x=0, then btn_down with y=9 -> cursor stays x=0 and y=9 (saturation).
- Ship 0 at (0,0) NORTH -> cell y=-1 fails, place_err pulses, occupancy unchanged, ship_idx=0, state returns to MOVE.
- Ship 0 at (0,0) EAST, then ship 1 SOUTH at (2,0) -> overlap at (2,0), place_err, ship_idx stays 1. Move to (2,1) and place -> place_ok.
- Same-cycle btn_rotate and btn_right -> orientation increments, cursor unchanged. Buttons during busy have no effect.
- Place all five ships legally -> all_placed=1. start -> all_placed=0, every query_hit=0. Assert rst during a COMMIT -> all outputs return to reset values asynchronously.
